// File: rtl/pipe_ctrl.sv
// pipe_ctrl: N-stage pipeline control unit.
// It arbitrates stall requests into a stall bus and inserts one bubble
// behind the frozen stages. It also provides a registered flush/redirect
// path and a sticky stall watchdog.
// Optional perf counters: define PIPE_CTRL_PERF_EN to build stall_cycles and
// flush_count. When it is undefined, both ports are tied to zero.
module pipe_ctrl #(
    parameter int unsigned STAGES  = 6,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              stall_timeout,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    logic [STAGES-1:0] stall_raw;
    logic              flush_q;
    logic [PC_W-1:0]   new_pc_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              timeout_q, timeout_d;

    // Thermometer fill: the highest requesting stage freezes every stage below it
    always_comb begin
        logic acc;
        acc       = 1'b0;
        stall_raw = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            acc          = acc | stallreq[i];
            stall_raw[i] = acc;
        end
    end

    // Flush dominates freezing; reset forces the stall bus idle
    always_comb begin
        stall = (rst || flush_q) ? '0 : stall_raw;
    end

    // A bubble goes into the first stage that is not frozen, right behind the frozen ones
    always_comb begin
        bubble    = '0;
        for (int i = 1; i < int'(STAGES); i++) begin
            bubble[i] = stall[i-1] & ~stall[i];
        end
    end

    // Watchdog run length: counts consecutive frozen-PC cycles, saturating at TIMEOUT
    always_comb begin
        run_d     = run_q;
        timeout_d = timeout_q;
        if (flush_q || !stall[0]) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = RUN_W'(run_q + RUN_W'(1));
        end
        if (run_d == RUN_MAX) begin
            timeout_d = 1'b1;
        end
    end

    // Flush pulse, redirect target and watchdog state
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            flush_q   <= flush_req;
            if (flush_req) begin
                new_pc_q <= flush_pc;
            end
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Free-running perf counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall[0]) begin
                stall_cycles_q <= 32'(stall_cycles_q + 32'd1);
            end
            if (flush_q) begin
                flush_count_q <= 32'(flush_count_q + 32'd1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (STAGES=6, PC_W=32, TIMEOUT=4).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(
        .STAGES (6),
        .PC_W   (32),
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq     (stallreq),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        stallreq  = '0;
        flush_req = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] perf_one;
        logic [31:0] perf_three;
        logic [31:0] perf_ten;
`ifdef PIPE_CTRL_PERF_EN
        perf_one   = 32'd1;
        perf_three = 32'd3;
        perf_ten   = 32'd10;
`else
        perf_one   = 32'd0;
        perf_three = 32'd0;
        perf_ten   = 32'd0;
`endif
        rst       = 1'b1;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        tick();
        tick();

        // Reset state
        check("rst_stall",   32'(stall), 32'h0);
        check("rst_bubble",  32'(bubble), 32'h0);
        check("rst_flush",   32'(flush), 32'h0);
        check("rst_new_pc",  new_pc, 32'h0);
        check("rst_timeout", 32'(stall_timeout), 32'h0);
        check("rst_scyc",    stall_cycles, 32'h0);
        check("rst_fcnt",    flush_count, 32'h0);

        // Stall is forced low while rst is high
        stallreq = 6'b000100;
        #1;
        check("rst_force_stall",  32'(stall), 32'h0);
        check("rst_force_bubble", 32'(bubble), 32'h0);

        // ID load-use
        rst = 1'b0;
        #1;
        check("lu_stall",  32'(stall), 32'h07);
        check("lu_bubble", 32'(bubble), 32'h08);
        tick();
        stallreq = '0;
        #1;
        check("lu_rel_stall",  32'(stall), 32'h0);
        check("lu_rel_bubble", 32'(bubble), 32'h0);

        // EX div + IF, and the top stage
        stallreq = 6'b001010;
        #1;
        check("div_stall",  32'(stall), 32'h0F);
        check("div_bubble", 32'(bubble), 32'h10);
        stallreq = 6'b100000;
        #1;
        check("top_stall",  32'(stall), 32'h3F);
        check("top_bubble", 32'(bubble), 32'h00);
        stallreq = 6'b111111;
        #1;
        check("all_stall",  32'(stall), 32'h3F);
        check("all_bubble", 32'(bubble), 32'h00);
        stallreq = 6'b000001;
        #1;
        check("pc_stall",  32'(stall), 32'h01);
        check("pc_bubble", 32'(bubble), 32'h02);

        // Flush dominates a held stall
        do_reset();
        stallreq  = 6'b000100;
        flush_req = 1'b1;
        flush_pc  = 32'hBFC00380;
        tick();
        flush_req = 1'b0;
        #1;
        check("fl_flush",  32'(flush), 32'h1);
        check("fl_new_pc", new_pc, 32'hBFC00380);
        check("fl_stall",  32'(stall), 32'h0);
        check("fl_bubble", 32'(bubble), 32'h0);
        tick();
        check("fl2_flush",  32'(flush), 32'h0);
        check("fl2_stall",  32'(stall), 32'h07);
        check("fl2_bubble", 32'(bubble), 32'h08);
        check("fl2_new_pc", new_pc, 32'hBFC00380);
        stallreq = '0;
        check("fl_scyc", stall_cycles, perf_one);
        check("fl_fcnt", flush_count, perf_one);

        // Back-to-back flushes
        do_reset();
        flush_req = 1'b1;
        flush_pc  = 32'h100;
        tick();
        check("bb1_flush",  32'(flush), 32'h1);
        check("bb1_new_pc", new_pc, 32'h100);
        flush_pc = 32'h200;
        tick();
        check("bb2_flush",  32'(flush), 32'h1);
        check("bb2_new_pc", new_pc, 32'h200);
        flush_pc = 32'h300;
        tick();
        check("bb3_flush",  32'(flush), 32'h1);
        check("bb3_new_pc", new_pc, 32'h300);
        flush_req = 1'b0;
        tick();
        check("bb4_flush",  32'(flush), 32'h0);
        check("bb4_new_pc", new_pc, 32'h300);
        check("bb_fcnt",    flush_count, perf_three);

        // Watchdog fires on the 4th stalled edge and stays set
        do_reset();
        stallreq = 6'b000100;
        tick();
        tick();
        tick();
        check("wd3_timeout", 32'(stall_timeout), 32'h0);
        tick();
        check("wd4_timeout", 32'(stall_timeout), 32'h1);
        stallreq = '0;
        tick();
        check("wd_sticky", 32'(stall_timeout), 32'h1);
        do_reset();
        check("wd_rst", 32'(stall_timeout), 32'h0);

        // Run broken by a free cycle never fires; the 4th consecutive one does
        stallreq = 6'b000100;
        tick();
        tick();
        tick();
        stallreq = '0;
        tick();
        stallreq = 6'b000100;
        tick();
        tick();
        tick();
        check("wd_gap", 32'(stall_timeout), 32'h0);
        tick();
        check("wd_gap_fire", 32'(stall_timeout), 32'h1);

        // Perf counters and reset mid-stall
        do_reset();
        stallreq = 6'b000100;
        for (int n = 0; n < 10; n++) begin
            tick();
        end
        check("pf_scyc", stall_cycles, perf_ten);
        check("pf_fcnt", flush_count, 32'h0);
        rst = 1'b1;
        tick();
        check("pf_rst_scyc",    stall_cycles, 32'h0);
        check("pf_rst_timeout", 32'(stall_timeout), 32'h0);
        check("pf_rst_stall",   32'(stall), 32'h0);

        // Pending flush is discarded under reset
        flush_req = 1'b1;
        flush_pc  = 32'hDEAD0000;
        tick();
        check("rst_flush_drop", 32'(flush), 32'h0);
        check("rst_pc_drop",    new_pc, 32'h0);
        rst       = 1'b0;
        flush_req = 1'b0;
        stallreq  = '0;
        tick();
        check("post_flush", 32'(flush), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
